cond_flag_stage: RTL and testbench

Condition-and-flags stage directly downstream of the ALU and its overflow detector. Each cycle it derives N and Z from the ALU result, takes C and V from the ALU carry and overflow outputs, and holds NZCV in an architectural flags register. It evaluates the instruction's 4-bit condition field against the current flags and registers the gated write-enables (PC, register file, memory) for the next stage. A stall/flush handshake lets the pipeline freeze or squash the stage.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/condCheck.sv | 33 +++
 rtl/cond_flag_stage.sv | 88 ++++++++
 tb/tb_cond_flag_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU-side types: condition encodings, flag layout, flag-write mask bits.
package alu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/condCheck.sv
// Combinational condition evaluator: 4-bit condition field against NZCV.
module condCheck
  import alu_pkg::*;
(
  input  cond_t  cond,
  input  flags_t flags,
  output logic   condEx
);

  // Decode the condition against the supplied flags; the reserved code never passes.
  always_comb begin
    condEx = 1'b0;
    case (cond)
      COND_EQ: condEx = flags.z;
      COND_NE: condEx = !flags.z;
      COND_CS: condEx = flags.c;
      COND_CC: condEx = !flags.c;
      COND_MI: condEx = flags.n;
      COND_PL: condEx = !flags.n;
      COND_VS: condEx = flags.v;
      COND_VC: condEx = !flags.v;
      COND_HI: condEx = flags.c & !flags.z;
      COND_LS: condEx = !flags.c | flags.z;
      COND_GE: condEx = (flags.n == flags.v);
      COND_LT: condEx = (flags.n != flags.v);
      COND_GT: condEx = !flags.z & (flags.n == flags.v);
      COND_LE: condEx = flags.z | (flags.n != flags.v);
      COND_AL: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_stage.sv
// Condition/flags stage: holds NZCV, evaluates the condition field against the
// registered flags and registers the gated write-enables for the next stage.
module cond_flag_stage
  import alu_pkg::*;
#(
  parameter int unsigned bits = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [3:0]      cond,
  input  logic [1:0]      flag_w,
  input  logic            pcs,
  input  logic            reg_w,
  input  logic            mem_w,
  input  logic            no_write,
  input  logic [bits-1:0] alu_result,
  input  logic            alu_carry,
  input  logic            alu_overflow,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic            pcs_o,
  output logic            reg_w_o,
  output logic            mem_w_o,
  output logic            cond_ex_o,
  output logic [3:0]      flags_o
);

  flags_t flagsQ;
  flags_t liveFlags;
  logic   condEx;
  logic   flagUpdate;

  // Flags produced by the current ALU operation.
  always_comb begin
    liveFlags   = '0;
    liveFlags.n = alu_result[bits-1];
    liveFlags.z = (alu_result == '0);
    liveFlags.c = alu_carry;
    liveFlags.v = alu_overflow;
  end

  // Condition is judged on the registered flags only; no live-flag bypass.
  condCheck uCondCheck (
    .cond   (cond_t'(cond)),
    .flags  (flagsQ),
    .condEx (condEx)
  );

  assign flagUpdate = in_valid & condEx & !stall & !flush;

  // Architectural flags register; each mask half loads independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      flagsQ <= '0;
    end else if (flagUpdate) begin
      if (flag_w[FLAGW_NZ]) begin
        flagsQ.n <= liveFlags.n;
        flagsQ.z <= liveFlags.z;
      end
      if (flag_w[FLAGW_CV]) begin
        flagsQ.c <= liveFlags.c;
        flagsQ.v <= liveFlags.v;
      end
    end
  end

  // Output register: flush squashes, stall holds, otherwise load gated enables.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      pcs_o     <= 1'b0;
      reg_w_o   <= 1'b0;
      mem_w_o   <= 1'b0;
      cond_ex_o <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      pcs_o     <= pcs & condEx & in_valid;
      reg_w_o   <= reg_w & !no_write & condEx & in_valid;
      mem_w_o   <= mem_w & condEx & in_valid;
      cond_ex_o <= condEx & in_valid;
    end
  end

  assign flags_o = flagsQ;

endmodule

// File: tb/tb_cond_flag_stage.sv
// Scoreboard bench for cond_flag_stage: driver predicts each cycle's outputs
// from a behavioural model, monitor compares after every rising edge.
module tb_cond_flag_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [3:0]  cond;
  logic [1:0]  flag_w;
  logic        pcs;
  logic        reg_w;
  logic        mem_w;
  logic        no_write;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        pcs_o;
  logic        reg_w_o;
  logic        mem_w_o;
  logic        cond_ex_o;
  logic [3:0]  flags_o;

  int errors = 0;
  int checks = 0;

  logic [8:0] expQ[$];

  // Model state: flags as NZCV and the last expected output enables.
  bit mN, mZ, mC, mV;
  bit [4:0] mOut;

  cond_flag_stage #(.bits(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .cond(cond), .flag_w(flag_w),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .stall(stall), .flush(flush), .out_valid(out_valid), .pcs_o(pcs_o),
    .reg_w_o(reg_w_o), .mem_w_o(mem_w_o), .cond_ex_o(cond_ex_o), .flags_o(flags_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Condition pairs share a base test; the odd code of each pair is its negation.
  function automatic bit refCond(input int c, input bit n, input bit z, input bit cy, input bit v);
    bit base;
    case (c / 2)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: return (c == 14);
    endcase
    return (c % 2 == 1) ? !base : base;
  endfunction

  task automatic step(input bit rst, input bit iv, input int c, input int fw,
                      input bit p, input bit rw, input bit mw, input bit nw,
                      input logic [31:0] res, input bit cy, input bit ov,
                      input bit st, input bit fl);
    bit ce;
    @(negedge clk);
    reset = rst; in_valid = iv; cond = 4'(c); flag_w = 2'(fw);
    pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
    alu_result = res; alu_carry = cy; alu_overflow = ov;
    stall = st; flush = fl;
    if (rst) begin
      {mN, mZ, mC, mV} = 4'b0000;
      mOut = '0;
    end else if (fl) begin
      mOut = '0;
    end else if (!st) begin
      ce = refCond(c, mN, mZ, mC, mV);
      mOut = {iv, p && ce && iv, rw && !nw && ce && iv, mw && ce && iv, ce && iv};
      if (iv && ce) begin
        if (fw >= 2) begin
          mN = res[31];
          mZ = (res == 32'd0);
        end
        if (fw % 2 == 1) begin
          mC = cy;
          mV = ov;
        end
      end
    end
    expQ.push_back({mOut, mN, mZ, mC, mV});
  endtask

  // Monitor: compare the DUT against the oldest prediction after each edge.
  always @(posedge clk) begin
    logic [8:0] exp;
    logic [8:0] act;
    #1;
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      act = {out_valid, pcs_o, reg_w_o, mem_w_o, cond_ex_o, flags_o};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL outputs t=%0t {valid,pcs,regw,memw,condex,NZCV} got %b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b",
                 $time, act[8], act[7], act[6], act[5], act[4], act[3:0],
                 exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 0; cond = 0; flag_w = 0; pcs = 0; reg_w = 0;
    mem_w = 0; no_write = 0; alu_result = 0; alu_carry = 0; alu_overflow = 0;
    stall = 0; flush = 0;
    // rst iv  c  fw p rw mw nw result        cy ov st fl
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'd0,        0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'd0,        0, 0, 0, 0);
    // AL register write after reset
    step(0, 1, 14, 0, 0, 1, 0, 0, 32'd5,       0, 0, 0, 0);
    // SUBS equal: Z=1 C=1, then EQ passes, NE fails
    step(0, 1, 14, 3, 0, 1, 0, 0, 32'd0,       1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 1, 0, 32'd7,        0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 1, 1, 0, 32'd7,        0, 0, 0, 0);
    // Negative with overflow: GE passes, LT fails
    step(0, 1, 14, 3, 0, 0, 0, 0, 32'h8000_0000, 0, 1, 0, 0);
    step(0, 1, 10, 0, 0, 1, 0, 0, 32'd1,       0, 0, 0, 0);
    step(0, 1, 11, 0, 0, 1, 0, 0, 32'd1,       0, 0, 0, 0);
    // Clear flags, then NZ-only write leaves C,V at 0
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'd0,        0, 0, 0, 0);
    step(0, 1, 14, 2, 0, 1, 0, 0, 32'd0,       1, 1, 0, 0);
    step(0, 1, 6, 0, 0, 1, 0, 0, 32'd0,        0, 0, 0, 0);
    // Stall three cycles with varying inputs, then stall+flush
    step(0, 1, 14, 3, 1, 1, 1, 0, 32'hFFFF_0000, 1, 1, 0, 0);
    step(0, 1, 14, 3, 1, 0, 0, 0, 32'd0,       0, 0, 1, 0);
    step(0, 0, 3, 1, 0, 1, 1, 1, 32'd9,        1, 0, 1, 0);
    step(0, 1, 14, 2, 1, 1, 1, 0, 32'h1,       0, 1, 1, 0);
    step(0, 1, 14, 3, 1, 1, 1, 0, 32'd0,       0, 0, 1, 1);
    // Reserved condition never writes anything; no_write masks reg_w
    step(0, 1, 15, 3, 1, 1, 1, 0, 32'd0,       1, 1, 0, 0);
    step(0, 1, 14, 0, 1, 1, 1, 1, 32'd3,       0, 0, 0, 0);
    // Reset while stalled and flushed
    step(1, 1, 14, 3, 1, 1, 1, 0, 32'd0,       1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'd0,        0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom();
      if ($urandom_range(0, 3) == 0) r = 32'd0;
      if ($urandom_range(0, 3) == 0) r[31] = 1'b1;
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
           1'($urandom()), 1'($urandom()), 1'($urandom()),
           $urandom_range(0, 3) == 0, r, 1'($urandom()), 1'($urandom()),
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
